// File: rtl/and_sync_checker_if.sv
// Bundle between the AND-sampler checker and its environment: run control,
// status, and the a/b drive plus q return of the sampler under test.
interface and_sync_checker_if #(
    parameter int ERR_W = 8
) ();
    logic             start;
    logic             a_out;
    logic             b_out;
    logic             q_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       vec_idx;

    // Checker side
    modport master (
        input  start, q_in,
        output a_out, b_out, busy, done, pass, err_count, vec_idx
    );

    // Environment side: run control plus the sampler's returned q
    modport slave (
        output start, q_in,
        input  a_out, b_out, busy, done, pass, err_count, vec_idx
    );
endinterface

// File: rtl/and_sync_checker.sv
// Stimulus driver and checker for a registered AND sampler. Walks a/b through
// 00,01,10,11, holds each vector HOLD_CYCLES cycles, samples q on the last
// held cycle and keeps a saturating mismatch count.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | outputs parked at 0, waiting for start
// S_DRIVE | vectors driven, q sampled at the end of each hold window
// S_DONE  | one-cycle done pulse, pass/err_count final
module and_sync_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int ITER        = 1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    and_sync_checker_if.master bus
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int IW = $clog2(ITER) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [HW-1:0]    hold_cnt;
    logic [IW-1:0]    iter_cnt;
    logic [1:0]       vec_idx;
    logic             a_r;
    logic             b_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [ERR_W-1:0] err_r;

    logic             sample;
    logic             mismatch;
    logic             last;
    logic [1:0]       vec_next;
    logic [ERR_W-1:0] err_next;

    // Compare point, next vector and the saturating error update
    always_comb begin
        sample   = (state == S_DRIVE) && (hold_cnt == HOLD_LAST);
        mismatch = sample && (bus.q_in != (vec_idx[1] & vec_idx[0]));
        last     = sample && (vec_idx == 2'd3) && (iter_cnt == ITER_LAST);
        vec_next = vec_idx + 2'd1;
        err_next = err_r;
        if (mismatch && (err_r != '1)) begin
            err_next = err_r + 1'b1;
        end
    end

    // Run sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            iter_cnt <= '0;
            vec_idx  <= 2'd0;
            a_r      <= 1'b0;
            b_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            err_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    a_r    <= 1'b0;
                    b_r    <= 1'b0;
                    if (bus.start) begin
                        state    <= S_DRIVE;
                        busy_r   <= 1'b1;
                        err_r    <= '0;
                        pass_r   <= 1'b0;
                        vec_idx  <= 2'd0;
                        hold_cnt <= '0;
                        iter_cnt <= '0;
                    end
                end
                S_DRIVE: begin
                    err_r <= err_next;
                    if (sample) begin
                        hold_cnt <= '0;
                        vec_idx  <= vec_next;
                        if (vec_idx == 2'd3) begin
                            iter_cnt <= iter_cnt + 1'b1;
                        end
                        if (last) begin
                            state  <= S_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= (err_next == '0);
                            a_r    <= 1'b0;
                            b_r    <= 1'b0;
                        end else begin
                            // drive tracks the vector index that becomes current
                            a_r <= vec_next[1];
                            b_r <= vec_next[0];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.a_out     = a_r;
    assign bus.b_out     = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.vec_idx   = vec_idx;

endmodule

// File: tb/tb_and_sync_checker.sv
// Bench for and_sync_checker: six instances with different parameters and
// different sampler models on q_in (correct, stuck-1, inverted, 2-stage).
module tb_and_sync_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    and_sync_checker_if #(.ERR_W(8)) bus0 ();
    and_sync_checker_if #(.ERR_W(8)) bus1 ();
    and_sync_checker_if #(.ERR_W(8)) bus2 ();
    and_sync_checker_if #(.ERR_W(2)) bus3 ();
    and_sync_checker_if #(.ERR_W(8)) bus4 ();
    and_sync_checker_if #(.ERR_W(8)) bus5 ();

    and_sync_checker #(.HOLD_CYCLES(4), .ITER(1), .ERR_W(8)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    and_sync_checker #(.HOLD_CYCLES(4), .ITER(1), .ERR_W(8)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    and_sync_checker #(.HOLD_CYCLES(4), .ITER(2), .ERR_W(8)) u2 (.clk(clk), .rst(rst), .bus(bus2));
    and_sync_checker #(.HOLD_CYCLES(4), .ITER(2), .ERR_W(2)) u3 (.clk(clk), .rst(rst), .bus(bus3));
    and_sync_checker #(.HOLD_CYCLES(3), .ITER(1), .ERR_W(8)) u4 (.clk(clk), .rst(rst), .bus(bus4));
    and_sync_checker #(.HOLD_CYCLES(2), .ITER(2), .ERR_W(8)) u5 (.clk(clk), .rst(rst), .bus(bus5));

    // Sampler models driving q_in
    logic s4 = 1'b0;
    logic s5 = 1'b0;
    initial begin
        bus0.q_in = 1'b0;
        bus3.q_in = 1'b0;
        bus4.q_in = 1'b0;
        bus5.q_in = 1'b0;
    end
    assign bus1.q_in = 1'b1;
    assign bus2.q_in = 1'b1;
    always @(posedge clk) begin
        bus0.q_in <= bus0.a_out & bus0.b_out;
        bus3.q_in <= ~(bus3.a_out & bus3.b_out);
        s4        <= bus4.a_out & bus4.b_out;
        bus4.q_in <= s4;
        s5        <= bus5.a_out & bus5.b_out;
        bus5.q_in <= s5;
    end

    // Capture result of each fault instance when its done pulses
    int done_cnt [1:5];
    int cap_err  [1:5];
    int cap_pass [1:5];
    initial begin
        for (int i = 1; i <= 5; i++) begin
            done_cnt[i] = 0;
            cap_err[i]  = 0;
            cap_pass[i] = 0;
        end
    end
    always @(negedge clk) begin
        if (bus1.done) begin done_cnt[1]++; cap_err[1] = int'(bus1.err_count); cap_pass[1] = int'(bus1.pass); end
        if (bus2.done) begin done_cnt[2]++; cap_err[2] = int'(bus2.err_count); cap_pass[2] = int'(bus2.pass); end
        if (bus3.done) begin done_cnt[3]++; cap_err[3] = int'(bus3.err_count); cap_pass[3] = int'(bus3.pass); end
        if (bus4.done) begin done_cnt[4]++; cap_err[4] = int'(bus4.err_count); cap_pass[4] = int'(bus4.pass); end
        if (bus5.done) begin done_cnt[5]++; cap_err[5] = int'(bus5.err_count); cap_pass[5] = int'(bus5.pass); end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // {busy,done,a,b,vec,pass} of instance 0 packed for one-shot compare
    function automatic int snap0();
        return int'({bus0.busy, bus0.done, bus0.a_out, bus0.b_out, bus0.vec_idx, bus0.pass});
    endfunction

    typedef struct {
        int         cyc;
        logic       busy;
        logic       done;
        logic       a;
        logic       b;
        logic [1:0] vec;
        logic       pass;
    } clean_t;

    typedef struct {
        int   idx;
        int   exp_err;
        logic exp_pass;
    } fault_t;

    clean_t tbl  [10];
    fault_t ftbl [5];

    initial begin
        int k;
        int busy_n;
        int done_at;
        int base [1:5];
        bit all_done;

        // Clean run expectations, cycle offsets after the edge that samples start
        tbl[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[2] = '{5,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[3] = '{8,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[4] = '{9,  1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[5] = '{12, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[6] = '{13, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
        tbl[7] = '{16, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
        tbl[8] = '{17, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[9] = '{18, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};

        // Fault instances: stuck-1 x1 / x2 passes, inverted saturating, 2-stage
        // 2-stage with HOLD=2, ITER=2: q at each compare is the previous vector's
        // AND, so 11 of pass 0, 00 of pass 1 and 11 of pass 1 mismatch -> 3.
        ftbl[0] = '{1, 3, 1'b0};
        ftbl[1] = '{2, 6, 1'b0};
        ftbl[2] = '{3, 3, 1'b0};
        ftbl[3] = '{4, 0, 1'b1};
        ftbl[4] = '{5, 3, 1'b0};

        bus0.start = 1'b1;
        bus1.start = 1'b1;
        bus2.start = 1'b1;
        bus3.start = 1'b1;
        bus4.start = 1'b1;
        bus5.start = 1'b1;

        // Reset held 3 cycles with start high: nothing starts
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_outputs[%0d]", i), snap0(), 0);
            chk($sformatf("rst_err[%0d]", i), int'(bus0.err_count), 0);
        end
        rst = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        bus4.start = 1'b0;
        bus5.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle0", int'(bus0.busy), 0);
        chk("post_rst_idle5", int'(bus5.busy), 0);

        // Clean run, table driven
        bus0.start = 1'b1;
        k = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (k < 10 && tbl[k].cyc == c) begin
                chk($sformatf("clean_t%0d", c), snap0(),
                    int'({tbl[k].busy, tbl[k].done, tbl[k].a, tbl[k].b, tbl[k].vec, tbl[k].pass}));
                chk($sformatf("clean_err_t%0d", c), int'(bus0.err_count), 0);
                k++;
            end
        end

        // Start re-pulsed mid-run is ignored
        @(negedge clk);
        bus0.start = 1'b1;
        busy_n  = 0;
        done_at = -1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            bus0.start = (c == 5);
            if (bus0.busy) busy_n++;
            if (bus0.done && done_at < 0) done_at = c;
        end
        bus0.start = 1'b0;
        chk("restart_busy_len", busy_n, 16);
        chk("restart_done_at", done_at, 17);

        // Reset mid-run at T+7
        bus0.start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus0.start = 1'b0;
        end
        chk("pre_rst_vec", int'(bus0.vec_idx), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_outputs", snap0(), 0);
        chk("midrun_rst_err", int'(bus0.err_count), 0);
        @(negedge clk);
        chk("midrun_rst_stays_idle", int'(bus0.busy), 0);

        // Following start gives a clean pass
        bus0.start = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (bus0.done) done_at = c;
        end
        chk("rerun_done_at", done_at, 17);
        chk("rerun_pass", int'(bus0.pass), 1);
        chk("rerun_err", int'(bus0.err_count), 0);

        // Fault-injection instances run together
        @(negedge clk);
        for (int i = 1; i <= 5; i++) base[i] = done_cnt[i];
        bus1.start = 1'b1;
        bus2.start = 1'b1;
        bus3.start = 1'b1;
        bus4.start = 1'b1;
        bus5.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        bus4.start = 1'b0;
        bus5.start = 1'b0;
        all_done = 1'b0;
        for (int c = 0; c < 100 && !all_done; c++) begin
            @(negedge clk);
            all_done = 1'b1;
            for (int i = 1; i <= 5; i++) if (done_cnt[i] == base[i]) all_done = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fault%0d_done", ftbl[i].idx), done_cnt[ftbl[i].idx] - base[ftbl[i].idx], 1);
            chk($sformatf("fault%0d_err", ftbl[i].idx), cap_err[ftbl[i].idx], ftbl[i].exp_err);
            chk($sformatf("fault%0d_pass", ftbl[i].idx), cap_pass[ftbl[i].idx], int'(ftbl[i].exp_pass));
        end
        chk("sat_err_holds", int'(bus3.err_count), 3);
        chk("stuck_pass_holds", int'(bus2.pass), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
